// File: rtl/boot_loader.sv
// boot_loader: streams instruction words into the icache boot port,
// optionally pads the rest of the icache, then releases the PC.
module boot_loader #(
  parameter bit          FILL_EN   = 1'b1,
  parameter logic [31:0] FILL_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  boot_addr,
  output logic [31:0] boot_datai,
  output logic        boot_web,
  output logic        boot_up,
  output logic [8:0]  word_count
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  wptr;
  logic [7:0]  wptr_nxt;
  logic [7:0]  addr_nxt;
  logic [31:0] data_nxt;
  logic        web_nxt;
  logic        up_nxt;
  logic [8:0]  count_nxt;
  logic        accept;
  logic        at_top;
  logic        last_word;

  // Address 255 always terminates the load, so wptr never wraps in LOAD.
  assign in_ready  = (state == LOAD);
  assign accept    = in_valid & in_ready;
  assign at_top    = (wptr == 8'hFF);
  assign last_word = accept & (in_last | at_top);

  // State register and registered icache port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      wptr       <= 8'h00;
      boot_addr  <= 8'h00;
      boot_datai <= 32'h0;
      boot_web   <= 1'b1;
      boot_up    <= 1'b0;
      word_count <= 9'd0;
    end else begin
      state      <= state_nxt;
      wptr       <= wptr_nxt;
      boot_addr  <= addr_nxt;
      boot_datai <= data_nxt;
      boot_web   <= web_nxt;
      boot_up    <= up_nxt;
      word_count <= count_nxt;
    end
  end

  // Next-state and next-output decode; everything holds unless told.
  always_comb begin
    state_nxt = state;
    wptr_nxt  = wptr;
    addr_nxt  = boot_addr;
    data_nxt  = boot_datai;
    web_nxt   = boot_web;
    up_nxt    = boot_up;
    count_nxt = word_count;
    unique case (state)
      LOAD: begin
        if (accept) begin
          addr_nxt  = wptr;
          data_nxt  = in_data;
          web_nxt   = 1'b0;
          wptr_nxt  = wptr + 8'd1;
          count_nxt = word_count + 9'd1;
          if (last_word) begin
            if (FILL_EN && !at_top) begin
              state_nxt = FILL;
            end else begin
              state_nxt = DONE;
            end
          end
        end else begin
          web_nxt = 1'b1;
        end
      end
      FILL: begin
        addr_nxt = wptr;
        data_nxt = FILL_WORD;
        web_nxt  = 1'b0;
        wptr_nxt = wptr + 8'd1;
        if (at_top) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        // First DONE edge closes the final write and releases the PC.
        web_nxt = 1'b1;
        up_nxt  = 1'b1;
      end
      default: begin
        state_nxt = LOAD;
      end
    endcase
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed checks of boot_loader with and
// without fill, against a small icache model.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        in_last = 1'b0;
  logic        rdy [2];
  logic [7:0]  addr [2];
  logic [31:0] dat [2];
  logic        web [2];
  logic        up [2];
  logic [8:0]  cnt [2];
  logic [31:0] mem [2][256];
  logic        clr = 1'b1;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  boot_loader #(.FILL_EN(1'b1), .FILL_WORD(32'h0)) u_fill (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(rdy[0]),
    .boot_addr(addr[0]), .boot_datai(dat[0]), .boot_web(web[0]),
    .boot_up(up[0]), .word_count(cnt[0])
  );

  boot_loader #(.FILL_EN(1'b0), .FILL_WORD(32'h0)) u_nofill (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(rdy[1]),
    .boot_addr(addr[1]), .boot_datai(dat[1]), .boot_web(web[1]),
    .boot_up(up[1]), .word_count(cnt[1])
  );

  // icache model: captures a write on the edge that ends its cycle
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        for (int k = 0; k < 256; k++) mem[i][k] <= 32'hDEAD_BEEF;
      end else if (web[i] === 1'b0) begin
        mem[i][addr[i]] <= dat[i];
      end
    end
  end

  typedef struct {
    logic        rdy;
    logic [7:0]  addr;
    logic [31:0] dat;
    logic        web;
    logic        up;
    logic [8:0]  cnt;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        v;
    logic [31:0] d;
    logic        last;
    exp_t        e;
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] a_words [4];

  function automatic exp_t mk(logic r, logic [7:0] a, logic [31:0] d,
                              logic w, logic u, logic [8:0] c);
    exp_t e;
    e.rdy = r; e.addr = a; e.dat = d;
    e.web = w; e.up = u; e.cnt = c;
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_inst(int i, exp_t e, string tag);
    chk($sformatf("%s.u%0d.ready", tag, i), 64'(rdy[i]), 64'(e.rdy));
    chk($sformatf("%s.u%0d.addr", tag, i), 64'(addr[i]), 64'(e.addr));
    chk($sformatf("%s.u%0d.datai", tag, i), 64'(dat[i]), 64'(e.dat));
    chk($sformatf("%s.u%0d.web", tag, i), 64'(web[i]), 64'(e.web));
    chk($sformatf("%s.u%0d.up", tag, i), 64'(up[i]), 64'(e.up));
    chk($sformatf("%s.u%0d.count", tag, i), 64'(cnt[i]), 64'(e.cnt));
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0;
    rst_n = 1'b0;
    #3;
    check_inst(0, mk(1'b1, 8'h0, 32'h0, 1'b1, 1'b0, 9'd0), "rst");
    check_inst(1, mk(1'b1, 8'h0, 32'h0, 1'b1, 1'b0, 9'd0), "rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic step(logic v, logic [31:0] d, logic l);
    in_valid = v; in_data = d; in_last = l;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_words[0] = 32'h11; a_words[1] = 32'h22;
    a_words[2] = 32'h33; a_words[3] = 32'h44;
    // gap sequence: word at 0, three idle cycles, word at 1
    vecs[0] = '{1'b1, 1'b1, 32'h5, 1'b0,
                mk(1'b1, 8'd0, 32'h5, 1'b0, 1'b0, 9'd1)};
    for (int k = 1; k < 4; k++)
      vecs[k] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0,
                  mk(1'b1, 8'd0, 32'h5, 1'b1, 1'b0, 9'd1)};
    vecs[4] = '{1'b0, 1'b1, 32'h6, 1'b0,
                mk(1'b1, 8'd1, 32'h6, 1'b0, 1'b0, 9'd2)};
    // four back-to-back words, last on 0x44
    for (int k = 0; k < 4; k++)
      vecs[5+k] = '{(k == 0), 1'b1, a_words[k], (k == 3),
                    mk((k != 3), 8'(k), a_words[k], 1'b0, 1'b0, 9'(k+1))};

    #6;
    clr = 1'b0;

    for (int k = 0; k < 9; k++) begin
      if (vecs[k].rst) do_reset();
      step(vecs[k].v, vecs[k].d, vecs[k].last);
      check_inst(0, vecs[k].e, $sformatf("vec%0d", k));
      check_inst(1, vecs[k].e, $sformatf("vec%0d", k));
    end

    // continue the 4-word load: fill vs no-fill
    for (int j = 4; j < 256; j++) begin
      step(1'b0, 32'h0, 1'b0);
      check_inst(0, mk(1'b0, 8'(j), 32'h0, 1'b0, 1'b0, 9'd4),
                 $sformatf("fill%0d", j));
      check_inst(1, mk(1'b0, 8'd3, 32'h44, 1'b1, 1'b1, 9'd4),
                 $sformatf("nofill%0d", j));
    end
    step(1'b0, 32'h0, 1'b0);
    check_inst(0, mk(1'b0, 8'd255, 32'h0, 1'b1, 1'b1, 9'd4), "filldone");
    for (int k = 0; k < 256; k++)
      chk($sformatf("mem_fill[%0d]", k), 64'(mem[0][k]),
          64'((k < 4) ? a_words[k] : 32'h0));
    for (int k = 0; k < 4; k++)
      chk($sformatf("mem_nofill[%0d]", k), 64'(mem[1][k]),
          64'(a_words[k]));
    chk("mem_nofill[4]", 64'(mem[1][4]), 64'(32'hDEAD_BEEF));

    // input is ignored once DONE
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 32'h99, 1'b1);
      check_inst(0, mk(1'b0, 8'd255, 32'h0, 1'b1, 1'b1, 9'd4), "done_hold");
      check_inst(1, mk(1'b0, 8'd3, 32'h44, 1'b1, 1'b1, 9'd4), "done_hold");
    end

    // 256 words, implicit last at address 255
    do_reset();
    for (int j = 0; j < 256; j++) begin
      step(1'b1, 32'hA500_0000 + 32'(j), 1'b0);
      for (int i = 0; i < 2; i++)
        check_inst(i, mk((j != 255), 8'(j), 32'hA500_0000 + 32'(j),
                         1'b0, 1'b0, 9'(j+1)), $sformatf("full%0d", j));
    end
    step(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check_inst(i, mk(1'b0, 8'd255, 32'hA500_00FF, 1'b1, 1'b1, 9'd256),
                 "fulldone");
      chk($sformatf("mem_full%0d[0]", i), 64'(mem[i][0]), 64'(32'hA500_0000));
      chk($sformatf("mem_full%0d[128]", i), 64'(mem[i][128]),
          64'(32'hA500_0080));
      chk($sformatf("mem_full%0d[255]", i), 64'(mem[i][255]),
          64'(32'hA500_00FF));
    end

    // reset in the middle of FILL at address 100
    do_reset();
    step(1'b1, 32'h77, 1'b1);
    check_inst(0, mk(1'b0, 8'd0, 32'h77, 1'b0, 1'b0, 9'd1), "mid0");
    for (int j = 1; j <= 100; j++) begin
      step(1'b0, 32'h0, 1'b0);
      chk($sformatf("mid%0d.addr", j), 64'(addr[0]), 64'(j));
      chk($sformatf("mid%0d.web", j), 64'(web[0]), 64'(1'b0));
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_inst(0, mk(1'b1, 8'd0, 32'h0, 1'b1, 1'b0, 9'd0), "midrst");
    check_inst(1, mk(1'b1, 8'd0, 32'h0, 1'b1, 1'b0, 9'd0), "midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b1, 32'hAA, 1'b0);
    check_inst(0, mk(1'b1, 8'd0, 32'hAA, 1'b0, 1'b0, 9'd1), "after_rst");
    step(1'b0, 32'h0, 1'b0);
    check_inst(0, mk(1'b1, 8'd0, 32'hAA, 1'b1, 1'b0, 9'd1), "after_rst_idle");
    chk("mem_rst[0]", 64'(mem[0][0]), 64'(32'hAA));
    chk("mem_rst[99]", 64'(mem[0][99]), 64'(32'h0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
